// File: rtl/fft_pkg.sv
// Shared types for the FFT result-side blocks.
package fft_pkg;

    localparam int unsigned BW = 16;

    typedef struct packed {
        logic signed [BW-1:0] re;
        logic signed [BW-1:0] im;
    } cplx_t;

    typedef logic [2*BW-1:0] mag_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT
    } peak_state_t;

endpackage

// File: rtl/mag_sq.sv
// Two-stage pipelined squared magnitude re^2 + im^2 with valid/tag pass-through.
module mag_sq #(
    parameter int unsigned bit_width = 16,
    parameter int unsigned TAG_W     = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [TAG_W-1:0]       i_tag,
    input  logic [bit_width-1:0]   i_re,
    input  logic [bit_width-1:0]   i_im,
    output logic                   o_valid,
    output logic [TAG_W-1:0]       o_tag,
    output logic [2*bit_width-1:0] o_mag
);

    localparam int unsigned MW = 2 * bit_width;

    logic signed [MW-1:0] w_re_ext;
    logic signed [MW-1:0] w_im_ext;
    logic signed [MW-1:0] w_re_sq;
    logic signed [MW-1:0] w_im_sq;

    logic             r_a_v;
    logic [TAG_W-1:0] r_a_tag;
    logic [MW-1:0]    r_re_sq;
    logic [MW-1:0]    r_im_sq;
    logic             r_b_v;
    logic [TAG_W-1:0] r_b_tag;
    logic [MW-1:0]    r_mag;

    // Sign-extend before squaring so the products are full width; each square is <= 2^(2bw-2).
    assign w_re_ext = MW'($signed(i_re));
    assign w_im_ext = MW'($signed(i_im));
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Stage A registers the squares, stage B the sum (max 2^(2bw-1), never overflows).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_v   <= 1'b0;
            r_a_tag <= '0;
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_b_v   <= 1'b0;
            r_b_tag <= '0;
            r_mag   <= '0;
        end else begin
            r_a_v   <= i_valid;
            r_a_tag <= i_tag;
            r_re_sq <= w_re_sq;
            r_im_sq <= w_im_sq;
            r_b_v   <= r_a_v;
            r_b_tag <= r_a_tag;
            r_mag   <= r_re_sq + r_im_sq;
        end
    end

    assign o_valid = r_b_v;
    assign o_tag   = r_b_tag;
    assign o_mag   = r_mag;

endmodule

// File: rtl/fft_peak_reader.sv
// Scans FFT bins MIN_BIN..N/2-1 after done rises and reports the strongest bin.
module fft_peak_reader
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 16,
    parameter int unsigned M         = 9,
    parameter int unsigned N         = 512,
    parameter int unsigned MIN_BIN   = 1,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [2*bit_width-1:0] wd,
    output logic [M-1:0]           adr,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [2*bit_width-1:0] peak_mag
);

    localparam int unsigned MW       = 2 * bit_width;
    localparam int unsigned LAST_BIN = N / 2 - 1;
    localparam int unsigned CW       = M + 1;

    peak_state_t   r_state;
    logic          r_done_q;
    logic [M-1:0]  r_adr;
    logic          r_busy;
    logic          r_peak_valid;
    logic [M-1:0]  r_peak_bin;
    logic [MW-1:0] r_peak_mag;
    logic [MW-1:0] r_max;
    logic [M-1:0]  r_best_bin;
    logic [CW-1:0] r_outst;

    logic [RD_LAT-1:0] r_dly_v;
    logic [M-1:0]      r_dly_tag [RD_LAT];

    logic          w_start;
    logic          w_issue;
    logic          w_mag_v;
    logic [M-1:0]  w_mag_tag;
    logic [MW-1:0] w_mag;
    logic          w_take;
    logic [MW-1:0] w_max_nxt;
    logic [M-1:0]  w_bin_nxt;
    logic          w_drained;

    assign w_start   = done & ~r_done_q;
    assign w_issue   = (r_state == SCAN);
    // Strictly greater: bins arrive in ascending order, so a tie keeps the lower bin.
    assign w_take    = w_mag_v && (w_mag > r_max);
    assign w_max_nxt = w_take ? w_mag : r_max;
    assign w_bin_nxt = w_take ? w_mag_tag : r_best_bin;
    // The last outstanding entry may be retiring this very cycle.
    assign w_drained = (r_outst == CW'(w_mag_v));

    // Address tag and valid delayed to line up with the RAM read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly_v <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_dly_tag[i] <= '0;
            end
        end else begin
            r_dly_v[0]   <= w_issue;
            r_dly_tag[0] <= r_adr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_dly_v[i]   <= r_dly_v[i-1];
                r_dly_tag[i] <= r_dly_tag[i-1];
            end
        end
    end

    mag_sq #(
        .bit_width (bit_width),
        .TAG_W     (M)
    ) u_mag_sq (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_dly_v[RD_LAT-1]),
        .i_tag   (r_dly_tag[RD_LAT-1]),
        .i_re    (wd[MW-1:bit_width]),
        .i_im    (wd[bit_width-1:0]),
        .o_valid (w_mag_v),
        .o_tag   (w_mag_tag),
        .o_mag   (w_mag)
    );

    // Count of issued addresses whose magnitude has not yet been compared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outst <= '0;
        end else begin
            case ({w_issue, w_mag_v})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Running maximum, re-armed at the start of every scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_max      <= '0;
            r_best_bin <= '0;
        end else if (r_state == IDLE && w_start) begin
            r_max      <= '0;
            r_best_bin <= M'(MIN_BIN);
        end else begin
            r_max      <= w_max_nxt;
            r_best_bin <= w_bin_nxt;
        end
    end

    // Scan sequencer with registered address, busy and report outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_done_q     <= 1'b0;
            r_adr        <= '0;
            r_busy       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_done_q     <= done;
            r_peak_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_adr <= '0;
                    if (w_start) begin
                        r_state <= SCAN;
                        r_adr   <= M'(MIN_BIN);
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (r_adr == M'(LAST_BIN)) begin
                        r_state <= DRAIN;
                        r_adr   <= '0;
                    end else begin
                        r_adr <= r_adr + M'(1);
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state      <= REPORT;
                        r_peak_valid <= 1'b1;
                        r_peak_bin   <= w_bin_nxt;
                        r_peak_mag   <= w_max_nxt;
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign adr        = r_adr;
    assign busy       = r_busy;
    assign peak_valid = r_peak_valid;
    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;

endmodule
